receiver: RTL

//   UART receive stage, downstream of the serial transmitter: recovers 8N1 frames from the

---
 rtl/uart_pkg.sv | 6 +
 rtl/sync_2ff.sv | 14 +
 rtl/receiver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and receive-state encoding shared by the UART transmit and receive sides.
package uart_pkg;
    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, reset value set by RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic meta;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) {o_q, meta} <= {2{RST_VAL}};
        else       {o_q, meta} <= {meta, i_d};
endmodule

// File: rtl/receiver.sv
// receiver: UART 8N1 receiver sampling mid-bit, with one-cycle valid/error pulses.
// Define RX_PARITY_EN for 8E1 frames with even-parity checking.
module receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic valid_n, ferr_n, perr_n, rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_rx), .o_q(rx_s));

`ifdef RX_PARITY_EN
    logic par, par_n;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) {par, o_parity_err} <= 2'b00;
        else       {par, o_parity_err} <= {par_n, perr_n};
`else
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            o_data      <= data_n;
            o_valid     <= valid_n;
            o_frame_err <= ferr_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = o_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        perr_n  = 1'b0;
`ifdef RX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START:
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            DATA:
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    idx_n   = (idx == 3'd7) ? idx : idx + 3'd1;
                    if (idx == 3'd7) state_n = AFTER_DATA;
                end
`ifdef RX_PARITY_EN
            PARITY:
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = STOP;
                end
`endif
            STOP:
                if (cnt == LAST) begin
                    // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : WAIT_IDLE;
                    ferr_n  = !rx_s;
`ifdef RX_PARITY_EN
                    perr_n  = rx_s && (par ^ (^shreg));
`endif
                    valid_n = rx_s && !perr_n;
                    data_n  = valid_n ? shreg : o_data;
                end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);
endmodule
